core_sched: RTL and testbench

CORE_SCHED -- requirements
Module: core_sched

---
 rtl/core_sched.sv | 165 ++++++++++++++++
 tb/tb_core_sched.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/core_sched.sv
// Round-robin scheduler granting one core at a time a multi-lap run of a 4-phase ring.
// Optional abort-on-request-drop behaviour is enabled by defining CORE_SCHED_ABORT_EN.
module core_sched #(
    parameter int unsigned NCORE = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [NCORE-1:0] req,
    input  logic [3:0]       run_len,
    output logic [NCORE-1:0] gnt,
    output logic [3:0]       phase,
    output logic             busy,
    output logic [NCORE-1:0] done
);

    localparam int unsigned IDXW = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int unsigned LAPW = 5;

    localparam logic [3:0]       PH_IDLE  = 4'b0000;
    localparam logic [3:0]       PH_FIRST = 4'b0001;
    localparam logic [3:0]       PH_LAST  = 4'b1000;
    localparam logic [IDXW-1:0]  LAST_RST = IDXW'(NCORE - 1);
    localparam logic [NCORE-1:0] ONE_HOT0 = NCORE'(1);
    localparam logic [LAPW-1:0]  LAP_ONE  = LAPW'(1);
    localparam logic [LAPW-1:0]  LAP_MAX  = LAPW'(16);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NCORE-1:0]  gnt_q,   gnt_d;
    logic [3:0]        phase_q, phase_d;
    logic              busy_q,  busy_d;
    logic [NCORE-1:0]  done_q,  done_d;
    logic [LAPW-1:0]   lap_q,   lap_d;
    logic [IDXW-1:0]   last_q,  last_d;
    logic [IDXW-1:0]   idx_q,   idx_d;

    logic              win_found_c;
    logic [IDXW-1:0]   win_idx_c;
    logic              abort_c;
    logic [LAPW-1:0]   lap_load_c;

    // Round-robin winner: first requesting core after the last one served.
    always_comb begin
        logic [IDXW-1:0] cand;
        cand        = '0;
        win_found_c = 1'b0;
        win_idx_c   = last_q;
        for (int unsigned i = 1; i <= NCORE; i++) begin
            cand = IDXW'((32'(last_q) + i) % NCORE);
            if (!win_found_c && req[cand]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand;
            end
        end
    end

    assign lap_load_c = (run_len == 4'd0) ? LAP_MAX : {1'b0, run_len};

`ifdef CORE_SCHED_ABORT_EN
    assign abort_c = (state_q == S_RUN) && !req[idx_q];
`else
    assign abort_c = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        done_d  = '0;
        lap_d   = lap_q;
        last_d  = last_q;
        idx_d   = idx_q;

        unique case (state_q)
            S_IDLE: begin
                gnt_d   = '0;
                phase_d = PH_IDLE;
                busy_d  = 1'b0;
                if (win_found_c) begin
                    gnt_d   = ONE_HOT0 << win_idx_c;
                    idx_d   = win_idx_c;
                    phase_d = PH_FIRST;
                    busy_d  = 1'b1;
                    lap_d   = lap_load_c;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (abort_c) begin
                    gnt_d   = '0;
                    phase_d = PH_IDLE;
                    busy_d  = 1'b0;
                    lap_d   = '0;
                    last_d  = idx_q;
                    state_d = S_IDLE;
                end else if (phase_q == PH_LAST) begin
                    if (lap_q > LAP_ONE) begin
                        lap_d   = lap_q - LAP_ONE;
                        phase_d = PH_FIRST;
                    end else begin
                        gnt_d   = '0;
                        phase_d = PH_IDLE;
                        busy_d  = 1'b0;
                        done_d  = gnt_q;
                        lap_d   = '0;
                        last_d  = idx_q;
                        state_d = S_DONE;
                    end
                end else begin
                    phase_d = phase_q << 1;
                end
            end

            S_DONE: begin
                gnt_d   = '0;
                phase_d = PH_IDLE;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d   = '0;
                phase_d = PH_IDLE;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            phase_q <= PH_IDLE;
            busy_q  <= 1'b0;
            done_q  <= '0;
            lap_q   <= '0;
            last_q  <= LAST_RST;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lap_q   <= lap_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt   = gnt_q;
    assign phase = phase_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_core_sched.sv
// Directed self-checking bench for core_sched (NCORE=4); honours CORE_SCHED_ABORT_EN.
module tb_core_sched;

    logic       CLK;
    logic       RSTN;
    logic [3:0] req;
    logic [3:0] run_len;
    logic [3:0] gnt;
    logic [3:0] phase;
    logic       busy;
    logic [3:0] done;

    int n_cmp;
    int n_bad;

    core_sched #(.NCORE(4)) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .req     (req),
        .run_len (run_len),
        .gnt     (gnt),
        .phase   (phase),
        .busy    (busy),
        .done    (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},   32'(gnt),   32'h0);
        check({tag, "_phase"}, 32'(phase), 32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
        check({tag, "_done"},  32'(done),  32'h0);
    endtask

    // Grant on the next edge, 4*laps phase cycles, then one done cycle.
    task automatic run_check(input string tag, input logic [3:0] exp_gnt, input int laps);
        logic [3:0] p;
        logic [3:0] one;
        one = 4'b0001;
        for (int c = 0; c < 4 * laps; c++) begin
            tick();
            p = one << (c % 4);
            check({tag, "_gnt"},   32'(gnt),   32'(exp_gnt));
            check({tag, "_phase"}, 32'(phase), 32'(p));
            check({tag, "_busy"},  32'(busy),  32'h1);
            check({tag, "_done0"}, 32'(done),  32'h0);
        end
        tick();
        check({tag, "_done"},      32'(done),  32'(exp_gnt));
        check({tag, "_dgnt"},      32'(gnt),   32'h0);
        check({tag, "_dphase"},    32'(phase), 32'h0);
        check({tag, "_dbusy"},     32'(busy),  32'h0);
    endtask

    initial begin
        logic [3:0] one;
        n_cmp   = 0;
        n_bad   = 0;
        one     = 4'b0001;
        RSTN    = 1'b0;
        req     = 4'b0000;
        run_len = 4'd1;

        repeat (2) tick();
        check_quiet("rst");
        RSTN = 1'b1;
        tick();
        check_quiet("idle");

        // Single one-lap run for core 0.
        req = 4'b0001; run_len = 4'd1;
        run_check("single", 4'b0001, 1);
        req = 4'b0000;
        tick();
        check_quiet("single_after");
        tick();
        check_quiet("single_idle");

        // Three laps for core 1.
        req = 4'b0010; run_len = 4'd3;
        run_check("multi", 4'b0010, 3);
        req = 4'b0000;
        tick();
        check_quiet("multi_after");

        // run_len of 0 means 16 laps.
        req = 4'b0100; run_len = 4'd0;
        run_check("wrap", 4'b0100, 16);
        req = 4'b0000;
        tick();
        check_quiet("wrap_after");

        // Reset in the third phase cycle abandons the run.
        req = 4'b0001; run_len = 4'd1;
        repeat (3) tick();
        check("mid_gnt",   32'(gnt),   32'h1);
        check("mid_phase", 32'(phase), 32'h4);
        #2 RSTN = 1'b0;
        #1;
        check_quiet("async_rst");
        tick();
        check_quiet("held_rst");
        RSTN = 1'b1;
        req = 4'b0100; run_len = 4'd1;
        run_check("post_rst", 4'b0100, 1);
        req = 4'b0000;
        tick();

        // Fresh priority, all cores requesting: rotation 0,1,2,3,0 every 6 cycles.
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        req = 4'b1111; run_len = 4'd1;
        for (int i = 0; i < 5; i++) begin
            run_check("rr", one << (i % 4), 1);
            if (i < 4) begin
                tick();
                check_quiet("rr_gap");
            end
        end
        req = 4'b0000;
        tick();
        check_quiet("rr_after");

        // Request drop in the second phase cycle.
        req = 4'b0001; run_len = 4'd2;
        tick();
        check("ab_gnt",   32'(gnt),   32'h1);
        check("ab_phase", 32'(phase), 32'h1);
        tick();
        check("ab_phase2", 32'(phase), 32'h2);
        req = 4'b0000;
`ifdef CORE_SCHED_ABORT_EN
        tick();
        check_quiet("abort");
        for (int i = 0; i < 8; i++) begin
            tick();
            check_quiet("abort_tail");
        end
`else
        for (int c = 2; c < 8; c++) begin
            tick();
            check("noab_phase", 32'(phase), 32'(one << (c % 4)));
            check("noab_gnt",   32'(gnt),   32'h1);
        end
        tick();
        check("noab_done", 32'(done), 32'h1);
        check("noab_gnt0", 32'(gnt),  32'h0);
        tick();
        check_quiet("noab_after");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
